// File: rtl/xor_checksum_if.sv
// xor_checksum_if: input stream and result handshake for the XOR checksum block
interface xor_checksum_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic             inLast;
  logic             inClear;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outSum;
  logic             outParity;
  logic [CNT_W-1:0] outCount;
  logic             outOverflow;
  modport master(output inValid, inData, inLast, inClear, outReady,
                 input inReady, outValid, outSum, outParity, outCount, outOverflow);
  modport slave(input inValid, inData, inLast, inClear, outReady,
                output inReady, outValid, outSum, outParity, outCount, outOverflow);
endinterface

// File: rtl/xor_checksum.sv
// xor_checksum: folds a framed word stream into XOR sum, parity and saturating word count
module xor_checksum #(parameter int WIDTH = 8, parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  xor_checksum_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, sum, nacc;
  logic [CNT_W-1:0] count, cnt, ncnt;
  logic ovf, ovf_q, par, novf, full;
  always_comb begin
    full = count == '1;
    nacc = acc ^ bus.inData;
    ncnt = full ? count : count + CNT_W'(1);
    novf = ovf | full;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
      sum <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
      par <= 1'b0;
    end else if (state == HOLD) begin
      if (bus.outReady) begin
        state <= ACCUM;
        acc <= '0;
        count <= '0;
        ovf <= 1'b0;
        sum <= '0;
        cnt <= '0;
        ovf_q <= 1'b0;
        par <= 1'b0;
      end
    end else if (bus.inClear) begin
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else if (bus.inValid) begin
      acc <= nacc;
      count <= ncnt;
      ovf <= novf;
      if (bus.inLast) begin
        state <= HOLD;
        sum <= nacc;
        cnt <= ncnt;
        ovf_q <= novf;
        par <= ^nacc;
      end
    end
  end
  assign bus.inReady = state == ACCUM;
  assign bus.outValid = state == HOLD;
  assign bus.outSum = sum;
  assign bus.outParity = par;
  assign bus.outCount = cnt;
  assign bus.outOverflow = ovf_q;
endmodule

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 SHALL have parameter CNT_W, default 8: word-counter width in bits, >= 1.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port inValid  input  1: inData/inLast valid this cycle.
REQ-006 SHALL have port inReady  output  1: block accepts an input word this cycle.
REQ-007 SHALL have port inData  input  WIDTH: word to fold into the running XOR.
REQ-008 SHALL have port inLast  input  1: accompanying word closes the frame.
REQ-009 SHALL have port inClear  input  1: abort the current frame, discarding partial results.
REQ-010 SHALL have port outValid  output  1: frame result valid.
REQ-011 SHALL have port outReady  input  1: consumer accepts the result.
REQ-012 SHALL have port outSum  output  WIDTH: bitwise XOR of all words in the frame.
REQ-013 SHALL have port outParity  output  1: XOR-reduction of outSum.
REQ-014 SHALL have port outCount  output  CNT_W: number of words in the frame, saturating.
REQ-015 SHALL have port outOverflow  output  1: the frame held more than 2^CNT_W-1 words.

Function
REQ-016 SHALL implement a two-state FSM with states ACCUM and HOLD.
REQ-017 SHALL drive inReady=1 and outValid=0 in ACCUM, and inReady=0 and outValid=1 in HOLD.
REQ-018 SHALL define an accepted beat as inValid&inReady.
REQ-019 SHALL, on an accepted beat in ACCUM, update acc<=acc^inData.
REQ-020 SHALL, on an accepted beat in ACCUM, increment count, saturating at 2^CNT_W-1.
REQ-021 SHALL set the overflow flag when a beat arrives while count is already at maximum; the flag SHALL stay sticky until the frame is released.
REQ-022 SHALL, on an accepted beat with inLast=1, register the final result (including that word) and enter HOLD; outValid SHALL rise the cycle after the last beat (1-cycle latency).
REQ-023 SHALL hold outSum, outParity, outCount and outOverflow stable throughout HOLD.
REQ-024 SHALL ignore inValid, inData, inLast and inClear while in HOLD.
REQ-025 SHALL, in HOLD with outReady=1, clear acc, count and overflow and return to ACCUM the next cycle.
REQ-026 SHALL NOT accept a new word in the release cycle itself (inReady=0 in HOLD).
REQ-027 SHALL, on inClear=1 in ACCUM, zero acc, count and overflow and remain in ACCUM.
REQ-028 SHALL give inClear priority over a simultaneous beat; that beat, including any inLast, SHALL be discarded.
REQ-029 SHALL drive all outputs as registered values, or as direct decodes of the FSM state for inReady/outValid.
REQ-030 SHALL compute outParity as the XOR-reduction of outSum.
REQ-031 SHALL accept a frame of exactly one word (inLast on the first beat).
REQ-032 SHALL produce no frame result from a cycle with inValid=0, whatever the value of inLast.
REQ-033 SHALL drive outputs during ACCUM as: outSum=0, outParity=0, outCount=0, outOverflow=0.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, enter ACCUM with acc=0, count=0, overflow=0, outValid=0, inReady=1 and all result outputs 0.
REQ-035 SHALL give rst priority over every other input, including a simultaneous beat, inClear or outReady.
REQ-036 SHALL discard any partial frame or pending result when reset is asserted mid-frame or in HOLD.

Verification
REQ-037 SHALL cover: WIDTH=8, beats 0x0F, 0xF0, 0x33(last) -> next cycle outValid=1, outSum=0xCC, outParity=0, outCount=3, outOverflow=0.
REQ-038 SHALL cover: single beat 0x01 with inLast -> outSum=0x01, outParity=1, outCount=1.
REQ-039 SHALL cover: result pending with outReady=0 for 5 cycles -> outValid=1, inReady=0 and outputs unchanged; outReady=1 -> ACCUM next cycle with inReady=1.
REQ-040 SHALL cover: CNT_W=2, 5 beats of 0x01 with the last flagged -> outSum=0x01, outCount=3, outOverflow=1.
REQ-041 SHALL cover: beats 0xAA, then 0x55 with inLast and inClear together, then 0x3C(last) -> outSum=0x3C, outCount=1.
REQ-042 SHALL cover: rst pulsed mid-frame after 0xFF and again while in HOLD -> outValid=0 and outCount=0; next frame 0x12(last) -> outSum=0x12.
